// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions for the ID stage.
// Holds the base-ISA opcode constants, the instruction-format enum, the
// default parameter values, and small helpers that classify an opcode and
// assemble the raw 32-bit immediate for a given format.
package riscv_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int NREG_DEF      = 32;
  localparam bit BYPASS_EN_DEF = 1'b1;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } fmt_e;

  // FMT_NONE doubles as "not an RV32I base opcode".
  function automatic fmt_e opcode_fmt(input logic [6:0] opc);
    fmt_e fmt;
    fmt = FMT_NONE;
    case (opc)
      OPC_OP:                                   fmt = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR,
      OPC_MISC_MEM, OPC_SYSTEM:                 fmt = FMT_I;
      OPC_STORE:                                fmt = FMT_S;
      OPC_BRANCH:                               fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:                       fmt = FMT_U;
      OPC_JAL:                                  fmt = FMT_J;
      default:                                  fmt = FMT_NONE;
    endcase
    return fmt;
  endfunction

  // Opcodes whose rd field names a destination register.
  function automatic logic writes_rd(input logic [6:0] opc);
    return (opc == OPC_OP)   || (opc == OPC_OP_IMM) || (opc == OPC_LOAD) ||
           (opc == OPC_LUI)  || (opc == OPC_AUIPC)  || (opc == OPC_JAL)  ||
           (opc == OPC_JALR);
  endfunction

  // 32-bit immediate, already sign-extended from instr[31]; R and unknown give 0.
  function automatic logic [31:0] decode_imm(input logic [31:0] instr, input fmt_e fmt);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Architectural register file with optional write-to-read bypass.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset (clears all entries)
//   we_i, waddr_i, wdata_i writeback port; x0 and indices >= NREG are ignored
//   raddr1_i, raddr2_i    combinational read indices
//   rdata1_o, rdata2_o    read data; x0 and indices >= NREG read as 0
module regfile_bypass
  import riscv_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREG      = NREG_DEF,
  parameter bit BYPASS_EN = BYPASS_EN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,
  input  logic [4:0]      waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      raddr1_i,
  input  logic [4:0]      raddr2_i,
  output logic [XLEN-1:0] rdata1_o,
  output logic [XLEN-1:0] rdata2_o
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            wr_en;

  always_comb begin
    wr_en  = we_i && (waddr_i != '0) && (32'(waddr_i) < NREG);
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[waddr_i[AW-1:0]] = wdata_i;
    end
  end

  // wr_en already excludes x0, so a bypass hit never returns data for x0.
  always_comb begin
    rdata1_o = '0;
    if ((raddr1_i != '0) && (32'(raddr1_i) < NREG)) begin
      if (BYPASS_EN && wr_en && (waddr_i == raddr1_i)) begin
        rdata1_o = wdata_i;
      end else begin
        rdata1_o = regs_q[raddr1_i[AW-1:0]];
      end
    end
  end

  always_comb begin
    rdata2_o = '0;
    if ((raddr2_i != '0) && (32'(raddr2_i) < NREG)) begin
      if (BYPASS_EN && wr_en && (waddr_i == raddr2_i)) begin
        rdata2_o = wdata_i;
      end else begin
        rdata2_o = regs_q[raddr2_i[AW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// RISC-V instruction decode stage with ID/EX pipeline register.
// Decodes the fetched instruction, reads operands from regfile_bypass,
// detects load-use hazards against the instruction held in ID/EX, and
// presents a registered ex_* bundle with valid/ready handshaking.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   if_valid_i/if_instr_i/if_pc_i fetch side; id_ready_o accepts it
//   flush_i                       drops the held bundle and any presented instruction
//   wb_we_i/wb_rd_i/wb_data_i     register file writeback
//   ex_ready_i/ex_valid_o         EX-side handshake
//   ex_*                          decoded fields, immediate, operands, control flags
module id_stage_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NREG      = NREG_DEF,
  parameter bit BYPASS_EN = BYPASS_EN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid_i,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            id_ready_o,
  input  logic            flush_i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            ex_ready_i,
  output logic            ex_valid_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [6:0]      ex_opcode_o,
  output logic [2:0]      ex_func3_o,
  output logic            ex_func7_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rs1_o,
  output logic [4:0]      ex_rs2_o,
  output logic [4:0]      ex_rd_o,
  output logic [XLEN-1:0] ex_rs1_data_o,
  output logic [XLEN-1:0] ex_rs2_data_o,
  output logic            ex_regwrite_o,
  output logic            ex_illegal_o
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic            func7;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            regwrite;
    logic            illegal;
  } idex_t;

  idex_t           idex_q, idex_d, dec;
  logic            ex_valid_q, ex_valid_d;

  logic [6:0]        opcode;
  logic [4:0]        rs1, rs2, rd;
  fmt_e              fmt;
  logic              uses_rs1, uses_rs2, rd_used;
  logic signed [31:0] imm32;
  logic              idx_bad;
  logic              hazard, id_ready, accept;
  logic [XLEN-1:0]   rs1_rdata, rs2_rdata;

  regfile_bypass #(
    .XLEN      (XLEN),
    .NREG      (NREG),
    .BYPASS_EN (BYPASS_EN)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wb_we_i),
    .waddr_i  (wb_rd_i),
    .wdata_i  (wb_data_i),
    .raddr1_i (rs1),
    .raddr2_i (rs2),
    .rdata1_o (rs1_rdata),
    .rdata2_o (rs2_rdata)
  );

  // Decode of the presented instruction.
  always_comb begin
    opcode   = if_instr_i[6:0];
    rd       = if_instr_i[11:7];
    rs1      = if_instr_i[19:15];
    rs2      = if_instr_i[24:20];
    fmt      = opcode_fmt(opcode);
    uses_rs1 = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    uses_rs2 = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    rd_used  = writes_rd(opcode);
    imm32    = decode_imm(if_instr_i, fmt);
    // Only index fields the instruction actually uses can make it illegal;
    // other formats reuse those bit positions for immediates.
    idx_bad  = (uses_rs1 && (32'(rs1) >= NREG)) ||
               (uses_rs2 && (32'(rs2) >= NREG)) ||
               (rd_used  && (32'(rd)  >= NREG));

    dec          = '0;
    dec.pc       = if_pc_i;
    dec.opcode   = opcode;
    dec.func3    = if_instr_i[14:12];
    dec.func7    = if_instr_i[30];
    dec.imm      = XLEN'(imm32);
    dec.rs1      = rs1;
    dec.rs2      = rs2;
    dec.rd       = rd;
    dec.rs1_data = rs1_rdata;
    dec.rs2_data = rs2_rdata;
    dec.regwrite = rd_used && (rd != '0);
    dec.illegal  = (fmt == FMT_NONE) || idx_bad;
  end

  // Handshake and ID/EX next state. Flush wins over acceptance and hazard;
  // a hazard with EX ready drains the held load and leaves a one-cycle bubble.
  always_comb begin
    hazard = ex_valid_q && (idex_q.opcode == OPC_LOAD) && (idex_q.rd != '0) &&
             ((uses_rs1 && (rs1 == idex_q.rd)) || (uses_rs2 && (rs2 == idex_q.rd)));
    id_ready = flush_i || ((!ex_valid_q || ex_ready_i) && !hazard);
    accept   = if_valid_i && id_ready && !flush_i;

    ex_valid_d = ex_valid_q;
    idex_d     = idex_q;
    if (flush_i) begin
      ex_valid_d = 1'b0;
    end else if (accept) begin
      ex_valid_d = 1'b1;
      idex_d     = dec;
    end else if (ex_ready_i) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      idex_q     <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      idex_q     <= idex_d;
    end
  end

  assign id_ready_o    = id_ready;
  assign ex_valid_o    = ex_valid_q;
  assign ex_pc_o       = idex_q.pc;
  assign ex_opcode_o   = idex_q.opcode;
  assign ex_func3_o    = idex_q.func3;
  assign ex_func7_o    = idex_q.func7;
  assign ex_imm_o      = idex_q.imm;
  assign ex_rs1_o      = idex_q.rs1;
  assign ex_rs2_o      = idex_q.rs2;
  assign ex_rd_o       = idex_q.rd;
  assign ex_rs1_data_o = idex_q.rs1_data;
  assign ex_rs2_data_o = idex_q.rs2_data;
  assign ex_regwrite_o = idex_q.regwrite;
  assign ex_illegal_o  = idex_q.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: a constant vector table, hand-written
// multi-cycle sequences, a second instance with NREG=16/no bypass, and a
// randomized phase checked against a behavioural model.
module tb_id_stage_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (XLEN=32, NREG=32, bypass on)
  logic        rst_n, if_valid, flush, wb_we, ex_ready;
  logic [31:0] if_instr, if_pc, wb_data;
  logic [4:0]  wb_rd;
  logic        id_ready, ex_valid, ex_f7, ex_rw, ex_ill;
  logic [31:0] ex_pc, ex_imm, ex_d1, ex_d2;
  logic [6:0]  ex_opc;
  logic [2:0]  ex_f3;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;

  // Second instance (NREG=16, bypass off)
  logic        if_valid_b, flush_b, wb_we_b, ex_ready_b;
  logic [31:0] if_instr_b, wb_data_b;
  logic [4:0]  wb_rd_b;
  logic        id_ready_b, ex_valid_b, ex_f7_b, ex_rw_b, ex_ill_b;
  logic [31:0] ex_pc_b, ex_imm_b, ex_d1_b, ex_d2_b;
  logic [6:0]  ex_opc_b;
  logic [2:0]  ex_f3_b;
  logic [4:0]  ex_rs1_b, ex_rs2_b, ex_rd_b;

  id_stage_pipe #(.XLEN(32), .NREG(32), .BYPASS_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid), .if_instr_i(if_instr),
    .if_pc_i(if_pc), .id_ready_o(id_ready), .flush_i(flush), .wb_we_i(wb_we),
    .wb_rd_i(wb_rd), .wb_data_i(wb_data), .ex_ready_i(ex_ready),
    .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_opcode_o(ex_opc),
    .ex_func3_o(ex_f3), .ex_func7_o(ex_f7), .ex_imm_o(ex_imm),
    .ex_rs1_o(ex_rs1), .ex_rs2_o(ex_rs2), .ex_rd_o(ex_rd),
    .ex_rs1_data_o(ex_d1), .ex_rs2_data_o(ex_d2),
    .ex_regwrite_o(ex_rw), .ex_illegal_o(ex_ill)
  );

  id_stage_pipe #(.XLEN(32), .NREG(16), .BYPASS_EN(1'b0)) dut16 (
    .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid_b), .if_instr_i(if_instr_b),
    .if_pc_i(if_pc), .id_ready_o(id_ready_b), .flush_i(flush_b), .wb_we_i(wb_we_b),
    .wb_rd_i(wb_rd_b), .wb_data_i(wb_data_b), .ex_ready_i(ex_ready_b),
    .ex_valid_o(ex_valid_b), .ex_pc_o(ex_pc_b), .ex_opcode_o(ex_opc_b),
    .ex_func3_o(ex_f3_b), .ex_func7_o(ex_f7_b), .ex_imm_o(ex_imm_b),
    .ex_rs1_o(ex_rs1_b), .ex_rs2_o(ex_rs2_b), .ex_rd_o(ex_rd_b),
    .ex_rs1_data_o(ex_d1_b), .ex_rs2_data_o(ex_d2_b),
    .ex_regwrite_o(ex_rw_b), .ex_illegal_o(ex_ill_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 1'b0; if_instr = 32'h0000_0013; flush = 1'b0; ex_ready = 1'b1;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    if_valid_b = 1'b0; if_instr_b = 32'h0000_0013; flush_b = 1'b0; ex_ready_b = 1'b1;
    wb_we_b = 1'b0; wb_rd_b = '0; wb_data_b = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [31:0] pc, imm, d1, d2;
    logic [6:0]  opc;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, ill;
  } bund_t;

  logic [31:0] mregs [32];
  bit          mvalid;
  bund_t       mb;

  function automatic bit m_legal(input logic [6:0] op);
    return op inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] in);
    logic [6:0] op;
    op = in[6:0];
    if (op inside {7'h13, 7'h03, 7'h67, 7'h0F, 7'h73}) return 32'($signed(in) >>> 20);
    if (op == 7'h23) return (32'($signed(in) >>> 20) & 32'hFFFF_FFE0) | ((in >> 7) & 32'h1F);
    if (op == 7'h63) return (32'($signed(in) >>> 19) & 32'hFFFF_F000) | (32'(in[7]) << 11)
                            | ((in >> 20) & 32'h7E0) | ((in >> 7) & 32'h1E);
    if (op inside {7'h37, 7'h17}) return in & 32'hFFFF_F000;
    if (op == 7'h6F) return (32'($signed(in) >>> 11) & 32'hFFF0_0000) | (in & 32'h000F_F000)
                            | ((in >> 9) & 32'h800) | ((in >> 20) & 32'h7FE);
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (wb_we && wb_rd == idx) return wb_data;
    return mregs[idx];
  endfunction

  function automatic bit m_hazard();
    logic [6:0] op;
    bit u1, u2;
    op = if_instr[6:0];
    u1 = !(op inside {7'h37, 7'h17, 7'h6F});
    u2 = op inside {7'h33, 7'h23, 7'h63};
    return mvalid && mb.opc == 7'h03 && mb.rd != 0 &&
           ((u1 && if_instr[19:15] == mb.rd) || (u2 && if_instr[24:20] == mb.rd));
  endfunction

  function automatic bit m_ready();
    return flush || ((!mvalid || ex_ready) && !m_hazard());
  endfunction

  task automatic m_clock();
    bit rdy;
    rdy = m_ready();
    if (!rst_n) begin
      mvalid = 0;
      for (int unsigned i = 0; i < 32; i++) mregs[i] = '0;
      return;
    end
    if (flush) mvalid = 0;
    else if (if_valid && rdy) begin
      mvalid = 1;
      mb.pc  = if_pc;             mb.imm = m_imm(if_instr);
      mb.opc = if_instr[6:0];     mb.rd  = if_instr[11:7];
      mb.rs1 = if_instr[19:15];   mb.rs2 = if_instr[24:20];
      mb.d1  = m_read(mb.rs1);    mb.d2  = m_read(mb.rs2);
      mb.ill = !m_legal(mb.opc);
      mb.rw  = (mb.opc inside {7'h03, 7'h13, 7'h17, 7'h33, 7'h37, 7'h67, 7'h6F}) && mb.rd != 0;
    end else if (ex_ready) mvalid = 0;
    if (wb_we && wb_rd != 0) mregs[wb_rd] = wb_data;
  endtask

  localparam logic [6:0] RND_OPS [12] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                          7'h37, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h7F};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    r[24:20] = 5'($urandom_range(0, 7));
    r[19:15] = 5'($urandom_range(0, 7));
    r[11:7]  = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 3) == 0) r[6:0] = 7'h03;
    else r[6:0] = RND_OPS[$urandom_range(0, 11)];
    return r;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        f7, rw, ill;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{32'hFFB0_0093, 32'hFFFF_FFFB, 5'd1,  1'b1, 1'b1, 1'b0}; // ADDI x1,x0,-5
    vecs[1]  = '{32'h1234_5137, 32'h1234_5000, 5'd2,  1'b0, 1'b1, 1'b0}; // LUI x2
    vecs[2]  = '{32'hFE20_AE23, 32'hFFFF_FFFC, 5'd28, 1'b1, 1'b0, 1'b0}; // SW x2,-4(x1)
    vecs[3]  = '{32'hFE20_8CE3, 32'hFFFF_FFF8, 5'd25, 1'b1, 1'b0, 1'b0}; // BEQ -8
    vecs[4]  = '{32'h0010_00EF, 32'h0000_0800, 5'd1,  1'b0, 1'b1, 1'b0}; // JAL x1,+2048
    vecs[5]  = '{32'h8000_0197, 32'h8000_0000, 5'd3,  1'b0, 1'b1, 1'b0}; // AUIPC x3
    vecs[6]  = '{32'h0031_8233, 32'h0000_0000, 5'd4,  1'b0, 1'b1, 1'b0}; // ADD x4,x3,x3
    vecs[7]  = '{32'h4020_8033, 32'h0000_0000, 5'd0,  1'b1, 1'b0, 1'b0}; // SUB x0
    vecs[8]  = '{32'hFFFF_FFFF, 32'h0000_0000, 5'd31, 1'b1, 1'b0, 1'b1}; // unknown opcode
    vecs[9]  = '{32'h0101_00E7, 32'h0000_0010, 5'd1,  1'b0, 1'b1, 1'b0}; // JALR x1,16(x2)
    vecs[10] = '{32'h0001_2283, 32'h0000_0000, 5'd5,  1'b0, 1'b1, 1'b0}; // LW x5,0(x2)

    do_reset();
    #1;
    chk("rst_ready", id_ready, 1);
    chk("rst_valid", ex_valid, 0);

    // Table: one instruction per cycle, EX always ready
    for (int unsigned i = 0; i < 11; i++) begin
      if_valid = 1'b1; if_instr = vecs[i].instr; if_pc = 32'h1000 + 4 * i;
      tick();
      chk("vec_valid", ex_valid, 1);
      chk("vec_pc", ex_pc, 32'h1000 + 4 * i);
      chk("vec_imm", ex_imm, vecs[i].imm);
      chk("vec_rd", ex_rd, vecs[i].rd);
      chk("vec_f7", ex_f7, vecs[i].f7);
      chk("vec_rw", ex_rw, vecs[i].rw);
      chk("vec_ill", ex_ill, vecs[i].ill);
    end

    // Load-use: LW x5 is now in EX; ADD x6,x5,x1 must wait one bubble
    if_instr = 32'h0012_8333; if_pc = 32'h3000;
    #1;
    chk("lu_ready0", id_ready, 0);
    tick();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_ready1", id_ready, 1);
    tick();
    chk("lu_issue_v", ex_valid, 1);
    chk("lu_issue_rd", ex_rd, 6);
    chk("lu_issue_rs1", ex_rs1, 5);
    if_valid = 1'b0;
    tick();

    // Bypass: writeback x3 and read it in the same cycle
    if_valid = 1'b1; if_instr = 32'h0031_8233; if_pc = 32'h4000;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h1234;
    tick();
    wb_we = 1'b0;
    chk("byp_rs1", ex_d1, 32'h1234);
    chk("byp_rs2", ex_d2, 32'h1234);
    if_instr = 32'h0001_8233; // ADD x4,x3,x0 reads stored value
    tick();
    chk("rf_rs1", ex_d1, 32'h1234);
    chk("rf_rs2", ex_d2, 0);
    if_instr = 32'h0000_03B3; // ADD x7,x0,x0 with a write to x0
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF;
    tick();
    wb_we = 1'b0;
    chk("x0_byp", ex_d1, 0);
    tick();
    chk("x0_rd", ex_d1, 0);

    // Stall: bundle holds for 3 cycles while operand register changes
    if_instr = 32'h0031_8233; if_pc = 32'h2000;
    tick();
    ex_ready = 1'b0; if_instr = 32'h0010_00EF; if_pc = 32'h2004;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h9999;
    for (int unsigned k = 0; k < 3; k++) begin
      #1;
      chk("stl_ready", id_ready, 0);
      tick();
      chk("stl_valid", ex_valid, 1);
      chk("stl_pc", ex_pc, 32'h2000);
      chk("stl_data", ex_d1, 32'h1234);
    end
    wb_we = 1'b0; ex_ready = 1'b1;
    #1;
    chk("stl_resume_rdy", id_ready, 1);
    tick();
    chk("stl_next_pc", ex_pc, 32'h2004);
    chk("stl_next_imm", ex_imm, 32'h800);

    // Flush with a held bundle and a presented instruction
    ex_ready = 1'b0; flush = 1'b1; if_instr = 32'hFFB0_0093; if_pc = 32'h5000;
    #1;
    chk("fl_ready", id_ready, 1);
    tick();
    flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1;
    chk("fl_valid", ex_valid, 0);
    tick();
    chk("fl_absent", ex_valid, 0);

    // Reset while stalled, with a writeback in the reset cycle
    if_valid = 1'b1; if_instr = 32'hFFB0_0093; if_pc = 32'h6000;
    tick();
    if_valid = 1'b0; ex_ready = 1'b0;
    wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'hABCD;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; wb_we = 1'b0;
    chk("mrst_valid", ex_valid, 0);
    chk("mrst_pc", ex_pc, 0);
    chk("mrst_imm", ex_imm, 0);
    chk("mrst_rd", ex_rd, 0);
    ex_ready = 1'b1; if_valid = 1'b1; if_instr = 32'h0034_83B3; // ADD x7,x9,x3
    tick();
    chk("mrst_rd_valid", ex_valid, 1);
    chk("mrst_x9", ex_d1, 0);
    chk("mrst_x3", ex_d2, 0);
    idle();
    tick();

    // NREG=16, no bypass
    if_valid_b = 1'b1; if_instr_b = 32'h001A_0093; // ADDI x1,x20,1
    tick();
    chk("n16_ill_rs1", ex_ill_b, 1);
    chk("n16_data_rs1", ex_d1_b, 0);
    if_instr_b = 32'h0011_0093; // ADDI x1,x2,1
    tick();
    chk("n16_legal", ex_ill_b, 0);
    if_instr_b = 32'h0010_0A13; // ADDI x20,x0,1
    tick();
    chk("n16_ill_rd", ex_ill_b, 1);
    if_instr_b = 32'h0000_03B3; wb_we_b = 1'b1; wb_rd_b = 5'd0; wb_data_b = 32'h5555;
    tick();
    wb_we_b = 1'b0;
    tick();
    chk("n16_x0", ex_d1_b, 0);
    if_instr_b = 32'h0021_03B3; wb_we_b = 1'b1; wb_rd_b = 5'd2; wb_data_b = 32'h55;
    tick();
    wb_we_b = 1'b0;
    chk("n16_nobyp", ex_d1_b, 0);
    tick();
    chk("n16_stored", ex_d1_b, 32'h55);
    idle();

    // Randomized phase against the model
    do_reset();
    mvalid = 0;
    for (int unsigned i = 0; i < 32; i++) mregs[i] = '0;
    for (int unsigned c = 0; c < 1500; c++) begin
      rst_n    = ($urandom_range(0, 99) != 0);
      if_valid = ($urandom_range(0, 9) < 8);
      flush    = ($urandom_range(0, 19) == 0);
      ex_ready = ($urandom_range(0, 9) < 7);
      wb_we    = 1'($urandom_range(0, 1));
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      if_instr = rand_instr();
      if_pc    = $urandom;
      #1;
      chk("rnd_ready", id_ready, m_ready());
      @(posedge clk);
      m_clock();
      #1;
      chk("rnd_valid", ex_valid, mvalid);
      if (mvalid) begin
        chk("rnd_pc", ex_pc, mb.pc);
        chk("rnd_opc", ex_opc, mb.opc);
        chk("rnd_imm", ex_imm, mb.imm);
        chk("rnd_rd", ex_rd, mb.rd);
        chk("rnd_d1", ex_d1, mb.d1);
        chk("rnd_d2", ex_d2, mb.d2);
        chk("rnd_rw", ex_rw, mb.rw);
        chk("rnd_ill", ex_ill, mb.ill);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
ID_STAGE_PIPE -- requirements
Module: id_stage_pipe

Interface
REQ-001 Parameters SHALL be: XLEN, 32, datapath/register width (32 or 64); NREG, 32, architectural registers (16 or 32); BYPASS_EN, 1, write-to-read bypass in register file.
REQ-002 Ports SHALL be (name direction width meaning):
- clk in 1 sole clock, rising edge
- rst_n in 1 reset, synchronous, active-low
- if_valid_i in 1 fetch instruction valid
- if_instr_i in 32 fetched instruction
- if_pc_i in XLEN fetched PC
- id_ready_o out 1 stage accepts instruction this cycle
- flush_i in 1 kill stage contents
- wb_we_i in 1 writeback enable
- wb_rd_i in 5 writeback register index
- wb_data_i in XLEN writeback data
- ex_ready_i in 1 EX accepts ex_* bundle
- ex_valid_o out 1 ex_* bundle valid
- ex_pc_o out XLEN PC
- ex_opcode_o out 7 opcode
- ex_func3_o out 3 func3
- ex_func7_o out 1 instr[30]
- ex_imm_o out XLEN sign-extended immediate
- ex_rs1_o/ex_rs2_o/ex_rd_o out 5 register indices
- ex_rs1_data_o/ex_rs2_data_o out XLEN operand data
- ex_regwrite_o out 1 instruction writes rd (rd!=0)
- ex_illegal_o out 1 unsupported opcode or index >= NREG

Function
REQ-003 Transfer in SHALL occur when if_valid_i && id_ready_o; transfer out when ex_valid_o && ex_ready_i.
REQ-004 Outputs ex_* SHALL be registered (ID/EX register); accepted instruction appears one cycle later; ex_* SHALL hold stable while ex_valid_o && !ex_ready_i.
REQ-005 hazard SHALL be ex_valid_o && ex_opcode_o==LOAD(0000011) && ex_rd_o!=0 && ((uses_rs1 && rs1==ex_rd_o) || (uses_rs2 && rs2==ex_rd_o)); uses_rs1 false for LUI/AUIPC/JAL, uses_rs2 true only for R, S, B formats.
REQ-006 id_ready_o SHALL equal flush_i || ((!ex_valid_o || ex_ready_i) && !hazard).
REQ-007 On hazard with ex_ready_i=1, ex_valid_o SHALL go 0 next cycle (one bubble); instruction SHALL be accepted the following cycle.
REQ-008 flush_i SHALL clear ex_valid_o next cycle and discard any instruction presented that cycle; flush overrides acceptance and hazard.
REQ-009 Immediate SHALL decode I, S, B, U, J formats, sign-extended from instr[31] to XLEN; R-format and unknown opcodes SHALL give 0.
REQ-010 Register file SHALL hold NREG x XLEN entries; x0 reads 0, writes to x0 ignored; write on rising edge when wb_we_i and wb_rd_i<NREG.
REQ-011 With BYPASS_EN=1, read index equal to wb_rd_i (nonzero, wb_we_i=1) SHALL return wb_data_i the same cycle; with BYPASS_EN=0 old value returned.
REQ-012 Operand data SHALL be captured into ID/EX at acceptance and SHALL NOT update while stalled.
REQ-013 Index >= NREG SHALL read 0 and set ex_illegal_o; opcode outside RV32I base set SHALL set ex_illegal_o, ex_regwrite_o=0.
REQ-014 ex_regwrite_o SHALL be 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR with rd!=0, else 0.

Reset
REQ-015 On rising clk with rst_n=0: ex_valid_o=0, all ex_* data fields 0, all registers 0; id_ready_o=1 once rst_n=1.
REQ-016 Reset mid-stall SHALL drop the held instruction; writeback in the reset cycle SHALL be ignored.

Structure
REQ-017 Opcode constants, format enum, and default parameter values SHALL live in the shared package riscv_pkg.
REQ-018 Register file SHALL be sub-module regfile_bypass (parameters XLEN, NREG, BYPASS_EN); decode and ID/EX register stay in id_stage_pipe.

Verification
REQ-019 Reset, then ADDI x1,x0,-5 (0xFFB00093) valid -> next cycle ex_valid_o=1, ex_imm_o=0xFFFFFFFB, ex_rd_o=1, ex_regwrite_o=1.
REQ-020 wb_we_i=1, wb_rd_i=3, wb_data_i=0x1234 while ADD x4,x3,x3 presented, BYPASS_EN=1 -> ex_rs1_data_o=ex_rs2_data_o=0x1234.
REQ-021 LW x5,0(x2) accepted, then ADD x6,x5,x1 -> id_ready_o=0 one cycle, one bubble (ex_valid_o=0), ADD issued next cycle.
REQ-022 ex_ready_i=0 for 3 cycles with bundle valid -> id_ready_o=0, ex_* unchanged; resumes on ex_ready_i=1.
REQ-023 flush_i=1 with valid instruction and ex_valid_o=1 -> next cycle ex_valid_o=0, instruction absent.
REQ-024 NREG=16, instruction with rs1=x20 -> ex_illegal_o=1, ex_rs1_data_o=0; write to x0 then read x0 -> 0.
